// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Purpose:
//   Instruction prefetch buffer between an instruction memory and a core.
//   A small FSM (IDLE / WAIT / DISCARD) issues word fetches to memory and
//   pushes returned words, tagged with their address, into a DEPTH-entry
//   FIFO. The core pops from the head. A redirect flushes the FIFO and
//   restarts fetching at the new address. A fetch that is already in flight
//   when a redirect arrives is allowed to complete, and its word is dropped.
//
// Parameters:
//   DEPTH    - FIFO entries (power of two, 2..16)
//   RESET_PC - first fetch address after reset
//
// Ports:
//   clk_i          in   1   clock, all state updates on the rising edge
//   rst_i          in   1   synchronous active-high reset
//   mem_req_o      out  1   fetch request (high in WAIT and DISCARD)
//   mem_addr_o     out  32  registered word-aligned fetch address
//   mem_ack_i      in   1   memory acknowledge, mem_data_i valid same cycle
//   mem_data_i     in   32  fetched instruction word
//   inst_valid_o   out  1   head entry available (suppressed during redirect)
//   inst_ready_i   in   1   core accepts head entry
//   inst_o         out  32  head instruction
//   inst_pc_o      out  32  address of head instruction
//   redirect_i     in   1   flush and refetch from redirect_pc_i
//   redirect_pc_i  in   32  new fetch address, bits [1:0] ignored
//   stall_cnt_o    out  16  (only with IPF_STATS_EN) saturating count of
//                           cycles with inst_ready_i=1 and inst_valid_o=0
//
// Optional feature macro: IPF_STATS_EN
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
`ifdef IPF_STATS_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_next;
  logic [31:0]   r_mem_addr;
  logic [31:0]   w_mem_addr_next;

  logic          w_not_empty;
  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;
  logic          w_unused;

  assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
  assign w_unused      = &{1'b0, redirect_pc_i[1:0]};

  assign w_not_empty  = (r_count != '0);
  assign mem_req_o    = (r_state != S_IDLE);
  assign mem_addr_o   = r_mem_addr;
  assign inst_valid_o = w_not_empty & ~redirect_i;
  // Head data is forced to zero when empty so the outputs read 0 out of reset
  // without needing to clear the storage arrays.
  assign inst_o       = w_not_empty ? r_instr_mem[r_head] : 32'h0;
  assign inst_pc_o    = w_not_empty ? r_pc_mem[r_head]    : 32'h0;

  // An ack only counts while a request is actually outstanding.
  assign w_ack  = mem_ack_i & mem_req_o;
  assign w_pop  = inst_valid_o & inst_ready_i;
  // Only WAIT pushes; WAIT is entered solely with room for the returning word,
  // so a push into a full FIFO cannot happen.
  assign w_push = (r_state == S_WAIT) & w_ack & ~redirect_i;

  always_comb begin
    w_state_next    = r_state;
    w_mem_addr_next = r_mem_addr;
    w_count_next    = r_count;
    w_fetch_pc_next = r_fetch_pc;

    if (redirect_i) begin
      w_count_next    = '0;
      w_fetch_pc_next = w_redirect_pc;
    end else begin
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        w_fetch_pc_next = r_fetch_pc + 32'd4;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (!redirect_i && (r_count < FULL)) begin
          w_state_next    = S_WAIT;
          w_mem_addr_next = r_fetch_pc;
        end
      end
      S_WAIT: begin
        if (w_ack) begin
          if (redirect_i) begin
            w_state_next = S_IDLE;
          end else if (w_count_next < FULL) begin
            // Back-to-back: issue the next word in the cycle after the ack.
            w_mem_addr_next = w_fetch_pc_next;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (redirect_i) begin
          // Request stays on the bus unchanged; its data will be thrown away.
          w_state_next = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (w_ack) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_mem_addr <= w_mem_addr_next;
      if (redirect_i) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + AW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + AW'(1);
        end
      end
    end
  end

  // Storage has no reset; contents are only observed when the count says so.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_pc_mem[r_tail]    <= r_mem_addr;
      r_instr_mem[r_tail] <= mem_data_i;
    end
  end

`ifdef IPF_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= 16'h0;
    end else if (inst_ready_i && !inst_valid_o && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
`ifdef IPF_STATS_EN
  logic [15:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
`ifdef IPF_STATS_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ack;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        chk_out;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic vec_t mk(input logic rst, input logic rdy, input logic ack,
                              input logic [31:0] data, input logic redir,
                              input logic [31:0] rpc, input logic req,
                              input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc, input logic [31:0] inst,
                              input logic chk_out);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.ack = ack; v.data = data; v.redir = redir;
    v.rpc = rpc; v.req = req; v.addr = addr; v.valid = valid; v.pc = pc;
    v.inst = inst; v.chk_out = chk_out;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic ack,
                       input logic [31:0] data, input logic redir, input logic [31:0] rpc);
    rst_i = rst; inst_ready_i = rdy; mem_ack_i = ack; mem_data_i = data;
    redirect_i = redir; redirect_pc_i = rpc;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  logic [31:0] addr_q [$];
  int          n_push;
  int          pops;
  logic [31:0] exp_pc;
  logic        prev_hold;
  logic        prev_rst;
  logic [31:0] prev_addr;
  logic        got;

  initial begin
    vecs[0]  = mk(1,1,0,32'h0,        0,32'h0,   0,32'h000,0,32'h000,32'h0,        1);
    vecs[1]  = mk(0,1,0,32'h0,        0,32'h0,   0,32'h000,0,32'h000,32'h0,        1);
    vecs[2]  = mk(0,1,1,32'hA000_0000,0,32'h0,   1,32'h000,0,32'h000,32'h0,        0);
    vecs[3]  = mk(0,1,1,32'hA000_0001,0,32'h0,   1,32'h004,1,32'h000,32'hA000_0000,1);
    vecs[4]  = mk(0,1,0,32'h0,        0,32'h0,   1,32'h008,1,32'h004,32'hA000_0001,1);
    vecs[5]  = mk(0,1,0,32'h0,        0,32'h0,   1,32'h008,0,32'h000,32'h0,        0);
    vecs[6]  = mk(0,0,0,32'h0,        0,32'h0,   1,32'h008,0,32'h000,32'h0,        0);
    vecs[7]  = mk(0,0,1,32'hA000_0002,0,32'h0,   1,32'h008,0,32'h000,32'h0,        0);
    vecs[8]  = mk(0,0,1,32'hA000_0003,0,32'h0,   1,32'h00C,1,32'h008,32'hA000_0002,1);
    vecs[9]  = mk(0,1,1,32'hA000_0004,1,32'h203, 1,32'h010,0,32'h000,32'h0,        0);
    vecs[10] = mk(0,1,0,32'h0,        0,32'h0,   0,32'h010,0,32'h000,32'h0,        0);
    vecs[11] = mk(0,1,0,32'h0,        0,32'h0,   1,32'h200,0,32'h000,32'h0,        0);
    vecs[12] = mk(0,1,0,32'h0,        1,32'h100, 1,32'h200,0,32'h000,32'h0,        0);
    vecs[13] = mk(0,1,0,32'h0,        0,32'h0,   1,32'h200,0,32'h000,32'h0,        0);
    vecs[14] = mk(0,1,1,32'hA000_0005,0,32'h0,   1,32'h200,0,32'h000,32'h0,        0);
    vecs[15] = mk(0,1,0,32'h0,        0,32'h0,   0,32'h200,0,32'h000,32'h0,        0);
    vecs[16] = mk(0,1,1,32'hA000_0006,0,32'h0,   1,32'h100,0,32'h000,32'h0,        0);
    vecs[17] = mk(0,1,0,32'h0,        0,32'h0,   1,32'h104,1,32'h100,32'hA000_0006,1);
    vecs[18] = mk(1,1,0,32'h0,        0,32'h0,   1,32'h104,0,32'h000,32'h0,        0);
    vecs[19] = mk(0,1,1,32'hA000_0007,0,32'h0,   0,32'h000,0,32'h000,32'h0,        1);
    vecs[20] = mk(0,1,0,32'h0,        0,32'h0,   1,32'h000,0,32'h000,32'h0,        0);
    vecs[21] = mk(0,1,1,32'hA000_0008,0,32'h0,   1,32'h000,0,32'h000,32'h0,        0);
    vecs[22] = mk(0,1,0,32'h0,        0,32'h0,   1,32'h004,1,32'h000,32'hA000_0008,1);

    // ---------------- table-driven directed sequence ----------------
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].ack, vecs[i].data, vecs[i].redir, vecs[i].rpc);
      #1;
      $display("vec %0d: req=%b addr=%h valid=%b pc=%h inst=%h", i,
               mem_req_o, mem_addr_o, inst_valid_o, inst_pc_o, inst_o);
      chk1 ($sformatf("vec%0d_req", i),   mem_req_o,    vecs[i].req);
      chk32($sformatf("vec%0d_addr", i),  mem_addr_o,   vecs[i].addr);
      chk1 ($sformatf("vec%0d_valid", i), inst_valid_o, vecs[i].valid);
      if (vecs[i].chk_out) begin
        chk32($sformatf("vec%0d_pc", i),   inst_pc_o, vecs[i].pc);
        chk32($sformatf("vec%0d_inst", i), inst_o,    vecs[i].inst);
      end
      tick();
    end

    // ---------------- fill to full with ready low ----------------
    do_reset();
    n_push = 0;
    addr_q.delete();
    for (int c = 0; c < 12; c++) begin
      mem_ack_i  = mem_req_o;
      mem_data_i = mem_word(mem_addr_o);
      if (mem_req_o) begin
        n_push++;
        addr_q.push_back(mem_addr_o);
        $display("fill push pc=%h", mem_addr_o);
      end
      #1;
      tick();
    end
    mem_ack_i = 1'b0;
    chk32("fill_push_count", 32'(n_push), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < addr_q.size()) chk32($sformatf("fill_addr%0d", k), addr_q[k], 32'(k * 4));
    end
    #1;
    chk1 ("fill_req_low", mem_req_o, 1'b0);
    chk1 ("fill_valid",   inst_valid_o, 1'b1);
    chk32("fill_head_pc", inst_pc_o, 32'h0);
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      if (mem_req_o) got = 1'b1;
      else tick();
    end
    chk1 ("refill_req", got, 1'b1);
    chk32("refill_addr", mem_addr_o, 32'h10);
    mem_ack_i  = 1'b1;
    mem_data_i = mem_word(32'h10);
    tick();
    mem_ack_i    = 1'b0;
    inst_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      $display("drain pop pc=%h inst=%h", inst_pc_o, inst_o);
      chk1 ($sformatf("drain%0d_valid", k), inst_valid_o, 1'b1);
      chk32($sformatf("drain%0d_pc", k),    inst_pc_o, 32'(k * 4));
      chk32($sformatf("drain%0d_inst", k),  inst_o, mem_word(32'(k * 4)));
      tick();
    end
    inst_ready_i = 1'b0;

    // ---------------- ack delayed 3 cycles ----------------
    do_reset();
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      if (mem_req_o) got = 1'b1;
      else tick();
    end
    chk1("delay_req_seen", got, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1 ($sformatf("delay%0d_req", c),  mem_req_o, 1'b1);
      chk32($sformatf("delay%0d_addr", c), mem_addr_o, 32'h0);
      chk1 ($sformatf("delay%0d_valid", c), inst_valid_o, 1'b0);
      tick();
    end
    mem_ack_i  = 1'b1;
    mem_data_i = mem_word(32'h0);
    tick();
    mem_ack_i = 1'b0;
    #1;
    $display("delayed ack entry pc=%h inst=%h", inst_pc_o, inst_o);
    chk1 ("delay_valid", inst_valid_o, 1'b1);
    chk32("delay_pc",    inst_pc_o, 32'h0);
    chk32("delay_inst",  inst_o, mem_word(32'h0));
    inst_ready_i = 1'b1;
    tick();
    #1;
    chk1("delay_one_entry", inst_valid_o, 1'b0);
    tick();

    // ---------------- randomized run against stream model ----------------
    do_reset();
    exp_pc    = 32'h0;
    prev_hold = 1'b0;
    prev_rst  = 1'b0;
    prev_addr = 32'h0;
    pops      = 0;
    for (int c = 0; c < 4000; c++) begin
      if (prev_hold) begin
        chk1 ("rnd_req_hold",  mem_req_o, 1'b1);
        chk32("rnd_addr_hold", mem_addr_o, prev_addr);
      end
      if (prev_rst) chk1("rnd_rst_req", mem_req_o, 1'b0);
      rst_i         = ($urandom_range(0, 249) == 0);
      redirect_i    = !rst_i && ($urandom_range(0, 19) == 0);
      redirect_pc_i = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      inst_ready_i  = ($urandom_range(0, 9) < 7);
      mem_ack_i     = mem_req_o && ($urandom_range(0, 2) != 0);
      mem_data_i    = mem_ack_i ? mem_word(mem_addr_o) : $urandom;
      #1;
      if (mem_req_o) chk32("rnd_addr_align", {30'h0, mem_addr_o[1:0]}, 32'h0);
      if (redirect_i) chk1("rnd_redirect_valid", inst_valid_o, 1'b0);
      if (prev_rst) begin
        chk1 ("rnd_rst_valid", inst_valid_o, 1'b0);
        chk32("rnd_rst_pc",    inst_pc_o, 32'h0);
        chk32("rnd_rst_inst",  inst_o, 32'h0);
      end
      if (!rst_i && !redirect_i && inst_valid_o && inst_ready_i) begin
        chk32("rnd_pop_pc",   inst_pc_o, exp_pc);
        chk32("rnd_pop_inst", inst_o, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (rst_i) exp_pc = 32'h0;
      else if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
      prev_hold = !rst_i && mem_req_o && !mem_ack_i;
      prev_addr = mem_addr_o;
      prev_rst  = rst_i;
      tick();
    end
    $display("random run: %0d instructions delivered", pops);
    chk1("rnd_liveness", (pops > 500), 1'b1);

`ifdef IPF_STATS_EN
    // ---------------- stall counter ----------------
    do_reset();
    inst_ready_i = 1'b1;
    #1;
    chk32("stall_reset", 32'(stall_cnt_o), 32'd0);
    tick();
    repeat (10) tick();
    mem_ack_i  = 1'b1;
    mem_data_i = mem_word(32'h0);
    tick();
    mem_ack_i = 1'b0;
    #1;
    $display("stall count after withheld ack = %0d", stall_cnt_o);
    chk1 ("stall_valid", inst_valid_o, 1'b1);
    chk32("stall_count", 32'(stall_cnt_o), 32'd12);
    repeat (65540) tick();
    #1;
    chk32("stall_saturate", 32'(stall_cnt_o), 32'h0000_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
